// File: rtl/mc10145_ctl_pkg.sv
// rtl/mc10145_ctl_pkg.sv - shared types, default timing and pin-order helpers for mc10145_ctl
package mc10145_ctl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WSU  = 3'd2,
    WPL  = 3'd3,
    WHD  = 3'd4,
    ACK  = 3'd5
  } state_e;

  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_PULSE_CYC = 2;
  localparam int DEF_HOLD_CYC  = 1;
  localparam int DEF_READ_CYC  = 2;

  localparam int CNT_W   = 3;
  localparam int MAX_CYC = 8;

  localparam logic [3:0] LAST_ADDR = 4'hF;

  // Bus bit 3 drives pin a0/d0 (chip MSB) down to bit 0 on pin a3/d3, so both orders coincide.
  function automatic logic [3:0] host_to_chip(input logic [3:0] n);
    return {n[3], n[2], n[1], n[0]};
  endfunction

  function automatic logic [3:0] chip_to_host(input logic [3:0] p);
    return {p[3], p[2], p[1], p[0]};
  endfunction

endpackage

// File: rtl/mc10145_ctl_if.sv
// rtl/mc10145_ctl_if.sv - host request/response and RAM pin bundle for mc10145_ctl
interface mc10145_ctl_if;

  logic       req;
  logic       wr;
  logic       clr;
  logic [3:0] addr;
  logic [3:0] wdata;
  logic       ack;
  logic [3:0] rdata;
  logic       busy;
  logic [3:0] ram_a;
  logic [3:0] ram_d;
  logic       ram_nen;
  logic       ram_nwrite;
  logic [3:0] ram_q;

  modport master (
    output req, wr, clr, addr, wdata, ram_q,
    input  ack, rdata, busy, ram_a, ram_d, ram_nen, ram_nwrite
  );

  modport slave (
    input  req, wr, clr, addr, wdata, ram_q,
    output ack, rdata, busy, ram_a, ram_d, ram_nen, ram_nwrite
  );

endinterface

// File: rtl/mc10145_ctl.sv
// rtl/mc10145_ctl.sv - strobe sequencer for one MC10145 16x4 RAM: read, write and sweep-clear
// All chip pins come straight from flops so nen/nwrite never glitch.
module mc10145_ctl
  import mc10145_ctl_pkg::*;
#(
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int READ_CYC  = DEF_READ_CYC
) (
  input  logic         clk,
  input  logic         reset,
  mc10145_ctl_if.slave bus
);

  if (SETUP_CYC < 1 || SETUP_CYC > MAX_CYC || PULSE_CYC < 1 || PULSE_CYC > MAX_CYC ||
      HOLD_CYC < 1 || HOLD_CYC > MAX_CYC || READ_CYC < 1 || READ_CYC > MAX_CYC) begin : g_bad_timing
    $error("mc10145_ctl: timing parameters must lie in 1..8");
  end

  // Counter holds remaining cycles minus one, which lets a value of 8 fit in 3 bits.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] READ_LD  = CNT_W'(READ_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       addr_q, addr_d;
  logic [3:0]       data_q, data_d;
  logic [3:0]       rdata_q, rdata_d;
  logic             sweep_q, sweep_d;
  logic             nen_q, nen_d;
  logic             nwrite_q, nwrite_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
      sweep_q  <= 1'b0;
      nen_q    <= 1'b1;
      nwrite_q <= 1'b1;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
      sweep_q  <= sweep_d;
      nen_q    <= nen_d;
      nwrite_q <= nwrite_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    sweep_d = sweep_q;

    unique case (state_q)
      IDLE: begin
        if (bus.clr) begin
          addr_d  = '0;
          data_d  = '0;
          sweep_d = 1'b1;
          cnt_d   = SETUP_LD;
          state_d = WSU;
        end else if (bus.req) begin
          addr_d  = bus.addr;
          data_d  = bus.wdata;
          sweep_d = 1'b0;
          if (bus.wr) begin
            cnt_d   = SETUP_LD;
            state_d = WSU;
          end else begin
            cnt_d   = READ_LD;
            state_d = RD;
          end
        end
      end
      RD: begin
        if (cnt_q == '0) begin
          rdata_d = chip_to_host(bus.ram_q);
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WSU: begin
        if (cnt_q == '0) begin
          cnt_d   = PULSE_LD;
          state_d = WPL;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WPL: begin
        if (cnt_q == '0) begin
          cnt_d   = HOLD_LD;
          state_d = WHD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WHD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (sweep_q && addr_q != LAST_ADDR) begin
          // Next clear location; nen stays low across the step.
          addr_d  = addr_q + 4'd1;
          cnt_d   = SETUP_LD;
          state_d = WSU;
        end else begin
          sweep_d = 1'b0;
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    nen_d    = (state_d == IDLE) || (state_d == ACK);
    nwrite_d = (state_d != WPL);
    ack_d    = (state_d == ACK);
    busy_d   = (state_d != IDLE);
  end

  assign bus.ram_a      = host_to_chip(addr_q);
  assign bus.ram_d      = host_to_chip(data_q);
  assign bus.ram_nen    = nen_q;
  assign bus.ram_nwrite = nwrite_q;
  assign bus.rdata      = rdata_q;
  assign bus.ack        = ack_q;
  assign bus.busy       = busy_q;

endmodule
